// File: rtl/pi_lf_pkg.sv
// Shared types and saturating helpers for the gear-shifting PI loop filter.
package pi_lf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_ZERO = 2'd0,
    ERR_POS  = 2'd1,
    ERR_NEG  = 2'd2
  } err_e;

  localparam int ARITH_W = 64;

  // Operands are carried wide enough that a+b never wraps; w sets the clamp.
  function automatic logic [ARITH_W-1:0] sat_add(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b,
                                                 input int w);
    logic [ARITH_W-1:0] lim;
    logic [ARITH_W-1:0] s;
    lim = (64'd1 << w) - 64'd1;
    s   = a + b;
    return (s > lim) ? lim : s;
  endfunction

  function automatic logic [ARITH_W-1:0] sat_sub(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b);
    return (b > a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/pi_lock_detector.sv
// Lock detector and gear FSM: window balance test to lock, same-sign run length to unlock.
module pi_lock_detector
  import pi_lf_pkg::*;
#(
  parameter int LOCK_WIN   = 64,
  parameter int LOCK_TH    = 4,
  parameter int UNLOCK_RUN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  err_e err,
  output logic gear_trk,
  output logic locked
);

  localparam int CW = $clog2(LOCK_WIN + 1);
  localparam int RW = $clog2(UNLOCK_RUN + 1);
  localparam int BW = CW + 1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bal;      // two's complement up-minus-dn
  logic [RW-1:0] run;
  logic          last_pos;

  logic [CW-1:0] cnt_inc;
  logic [BW-1:0] bal_inc;
  logic [BW-1:0] bal_abs;
  logic [RW-1:0] run_inc;
  logic          pos;

  always_comb begin
    pos     = (err == ERR_POS);
    cnt_inc = cnt + CW'(1);
    bal_inc = pos ? bal + BW'(1) : bal - BW'(1);
    bal_abs = bal_inc[BW-1] ? (~bal_inc + BW'(1)) : bal_inc;
    if (run == '0 || pos != last_pos)
      run_inc = RW'(1);
    else if (run == RW'(UNLOCK_RUN))
      run_inc = run;
    else
      run_inc = run + RW'(1);
  end

  assign gear_trk = (state == TRACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bal      <= '0;
      run      <= '0;
      last_pos <= 1'b0;
      locked   <= 1'b0;
    end else if (!en) begin
      state  <= IDLE;
      cnt    <= '0;
      bal    <= '0;
      run    <= '0;
      locked <= 1'b0;
    end else begin
      if (state == IDLE) state <= ACQ;
      if (err != ERR_ZERO) begin
        last_pos <= pos;
        if (state == TRACK) begin
          if (run_inc == RW'(UNLOCK_RUN)) begin
            state  <= ACQ;
            locked <= 1'b0;
            cnt    <= '0;
            bal    <= '0;
            run    <= '0;
          end else begin
            run <= run_inc;
          end
        end else begin
          // The run limit is deliberately ignored while acquiring.
          run <= run_inc;
          if (cnt_inc == CW'(LOCK_WIN)) begin
            cnt <= '0;
            bal <= '0;
            if (bal_abs <= BW'(LOCK_TH)) begin
              state  <= TRACK;
              locked <= 1'b1;
            end
          end else begin
            cnt <= cnt_inc;
            bal <= bal_inc;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pi_loop_filter_gs.sv
// Gear-shifting PI loop filter: saturating integrator plus proportional kick, gains from the lock FSM.
module pi_loop_filter_gs
  import pi_lf_pkg::*;
#(
  parameter int W          = 20,
  parameter int KP_ACQ     = 2000,
  parameter int KI_ACQ     = 64,
  parameter int KP_TRK     = 500,
  parameter int KI_TRK     = 8,
  parameter int INT_INIT   = 0,
  parameter int LOCK_WIN   = 64,
  parameter int LOCK_TH    = 4,
  parameter int UNLOCK_RUN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         dn,
  output logic [W-1:0] dac,
  output logic         dac_vld,
  output logic         locked,
  output logic [W-1:0] integ
);

  err_e               err;
  logic               gear_trk;
  logic [ARITH_W-1:0] kp;
  logic [ARITH_W-1:0] ki;
  logic [W-1:0]       integ_next;
  logic [W-1:0]       dac_next;

  pi_lock_detector #(
    .LOCK_WIN  (LOCK_WIN),
    .LOCK_TH   (LOCK_TH),
    .UNLOCK_RUN(UNLOCK_RUN)
  ) u_lock (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .err     (err),
    .gear_trk(gear_trk),
    .locked  (locked)
  );

  always_comb begin
    if (up && !dn)      err = ERR_POS;
    else if (dn && !up) err = ERR_NEG;
    else                err = ERR_ZERO;
  end

  // Gains follow the state registered before this edge, so a gear change lands one sample later.
  always_comb begin
    kp         = gear_trk ? ARITH_W'(KP_TRK) : ARITH_W'(KP_ACQ);
    ki         = gear_trk ? ARITH_W'(KI_TRK) : ARITH_W'(KI_ACQ);
    integ_next = integ;
    dac_next   = integ;
    case (err)
      ERR_POS: begin
        integ_next = W'(sat_add(ARITH_W'(integ), ki, W));
        dac_next   = W'(sat_add(ARITH_W'(integ_next), kp, W));
      end
      ERR_NEG: begin
        integ_next = W'(sat_sub(ARITH_W'(integ), ki));
        dac_next   = W'(sat_sub(ARITH_W'(integ_next), kp));
      end
      default: begin
        integ_next = integ;
        dac_next   = integ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      integ   <= W'(INT_INIT);
      dac     <= W'(INT_INIT);
      dac_vld <= 1'b0;
    end else if (en) begin
      integ   <= integ_next;
      dac     <= dac_next;
      dac_vld <= 1'b1;
    end else begin
      dac_vld <= 1'b0;
    end
  end

endmodule
